codificador_7seg: RTL
=====================

Name: codificador_7seg

Overview:
- Receiver/encoder for the 7-segment pattern bus. It is the inverse of the board's BCD-to-7-segment decoder.
- Samples an active-low a..g pattern, filters it for stability, and encodes it back to a 4-bit digit.
- Shifts accepted digits into a multi-digit BCD register for the ALU operand path.
- Feeds operand entry from a segment source (panel or loopback) instead of raw switches.

Parameters:
- ESTAVEL, 4: consecutive identical samples required to accept a pattern (legal range 2..255).
- NDIG, 2: number of BCD digits held in the accumulator (legal range 1..8).

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- SEG  in  7  active-low segment pattern; SEG[0]=a … SEG[6]=g; 0=segment lit.
- LIMPA  in  1  synchronous clear of accumulator and digit count.
- DIGITO  out  4  last accepted digit, [3] is MSB.
- VALIDO  out  1  one-cycle pulse: DIGITO updated and shifted in.
- ERRO  out  1  one-cycle pulse: stable pattern is not a legal code.
- VALOR  out  4*NDIG  accumulator; [3:0] is the newest digit, higher nibbles are older.
- CONTAGEM  out  4  digits held, saturates at NDIG.

Behaviour:
- Reset and LIMPA values:
  - RESET: DIGITO=0, VALIDO=0, ERRO=0, VALOR=0, CONTAGEM=0, state OCIOSO, stability counter 0, last-accepted pattern = blank (7'b1111111).
  - LIMPA clears only VALOR and CONTAGEM.
- Input stage: SEG registered once into seg_r. No other synchronisation.
- Stability counter: cnt resets to 1 when seg_r differs from its previous value, else increments, saturating at ESTAVEL.
- FSM states:
  - OCIOSO: wait for seg_r ≠ last-accepted. Go to FILTRANDO.
  - FILTRANDO: on any seg_r change, restart the count. When cnt reaches ESTAVEL, classify the pattern:
    - legal digit → pulse VALIDO, go to TRAVADO;
    - blank → no pulse, go to TRAVADO;
    - anything else → pulse ERRO, go to TRAVADO.
    - The classified pattern becomes last-accepted in every case.
  - TRAVADO: hold while seg_r == last-accepted. On a change, go to FILTRANDO.
- Latency: a new pattern held from edge k produces VALIDO/ERRO during the cycle after edge k+ESTAVEL (register stage + ESTAVEL samples). It is never earlier.
- Repeated digits: the same digit twice needs a different pattern (normally blank) between them. A glitch shorter than ESTAVEL samples followed by the same pattern generates nothing.
- Legal codes (a..g, active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
- On VALIDO:
  - DIGITO = code.
  - VALOR = {VALOR[4*NDIG-5:0], code}; the oldest digit is dropped when full.
  - CONTAGEM = min(CONTAGEM+1, NDIG).
- On ERRO: DIGITO, VALOR and CONTAGEM are unchanged.
- Simultaneous events:
  - LIMPA with VALIDO in the same cycle: VALOR = {0…, code}, CONTAGEM=1.
  - RESET has priority over everything.
- RESET mid-filter: any pending acceptance is lost. After reset, a pattern still present on SEG is re-filtered from scratch, since last-accepted is blank.
- VALIDO and ERRO are never high together. Each is high for exactly one cycle per acceptance.

Optional Feature:
- Macro: CODIFICADOR_HEX_EN.
- Defined: additionally accept A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000 as codes 10..15. The accumulator then holds hex nibbles.
- Undefined: those six patterns raise ERRO like any other illegal pattern.

Test Plan:
- RESET, then SEG=0010010 held 10 cycles with ESTAVEL=4 → exactly one VALIDO, in the cycle after edge 5 from the change; DIGITO=2, VALOR=8'h02, CONTAGEM=1.
- Sequence 7, blank, 3, blank, 5 (each held 6 cycles), NDIG=2 → three VALIDO pulses; final VALOR=8'h35, CONTAGEM=2 (the 7 is dropped).
- 9 held, 2-cycle glitch to 1111110, back to 9 → no extra VALIDO or ERRO; VALOR unchanged.
- SEG=1111110 held 6 cycles → one ERRO pulse, VALIDO stays 0, VALOR unchanged. Repeat with 0001000: ERRO without CODIFICADOR_HEX_EN; VALIDO with DIGITO=4'hA with it.
- LIMPA asserted in the same cycle as VALIDO for digit 4, VALOR previously 8'h12 → VALOR=8'h04, CONTAGEM=1.
- RESET asserted at filter count 2 with 8 on SEG, then released, 8 still held → VALOR=0 during reset; VALIDO ESTAVEL+1 cycles after release; DIGITO=8.

Source files
------------

// File: rtl/codificador_7seg.sv
// codificador_7seg: filters an active-low a..g segment pattern and encodes it back to a digit.
// Define CODIFICADOR_HEX_EN to also accept A..F as codes 10..15.
module codificador_7seg #(
  parameter int ESTAVEL = 4,
  parameter int NDIG    = 2
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic [6:0]        SEG,
  input  logic              LIMPA,
  output logic [3:0]        DIGITO,
  output logic              VALIDO,
  output logic              ERRO,
  output logic [4*NDIG-1:0] VALOR,
  output logic [3:0]        CONTAGEM
);

  localparam int         VW    = 4 * NDIG;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [7:0] EST   = 8'(ESTAVEL);
  localparam logic [3:0] NMAX  = 4'(NDIG);

  typedef enum logic [1:0] {
    OCIOSO,
    FILTRANDO,
    TRAVADO
  } estado_t;

  estado_t est_q, est_d;

  logic [6:0]    seg_r_q, seg_r_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [6:0]    ult_q, ult_d;
  logic [3:0]    digito_q, digito_d;
  logic          valido_q, valido_d;
  logic          erro_q, erro_d;
  logic [VW-1:0] valor_q, valor_d;
  logic [3:0]    cont_q, cont_d;

  logic          aceita;
  logic          cod_ok;
  logic [3:0]    cod;

  // Literals are {g,f,e,d,c,b,a}; a zero bit is a lit segment.
  always_comb begin
    cod_ok = 1'b1;
    cod    = 4'd0;
    case (seg_r_q)
      7'b1000000: cod = 4'd0;
      7'b1111001: cod = 4'd1;
      7'b0100100: cod = 4'd2;
      7'b0110000: cod = 4'd3;
      7'b0011001: cod = 4'd4;
      7'b0010010: cod = 4'd5;
      7'b0000010: cod = 4'd6;
      7'b1111000: cod = 4'd7;
      7'b0000000: cod = 4'd8;
      7'b0010000: cod = 4'd9;
`ifdef CODIFICADOR_HEX_EN
      7'b0001000: cod = 4'hA;
      7'b0000011: cod = 4'hB;
      7'b1000110: cod = 4'hC;
      7'b0100001: cod = 4'hD;
      7'b0000110: cod = 4'hE;
      7'b0001110: cod = 4'hF;
`endif
      default:    cod_ok = 1'b0;
    endcase
  end

  // cnt counts identical consecutive samples held in seg_r.
  always_comb begin
    seg_r_d = SEG;
    cnt_d   = cnt_q;
    if (SEG != seg_r_q) begin
      cnt_d = 8'd1;
    end else if (cnt_q != EST) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_comb begin
    est_d  = est_q;
    ult_d  = ult_q;
    aceita = 1'b0;
    unique case (est_q)
      OCIOSO, TRAVADO: begin
        if (seg_r_q != ult_q) est_d = FILTRANDO;
      end
      FILTRANDO: begin
        // Returning to the held pattern is a glitch, not a new entry.
        if (seg_r_q == ult_q) begin
          est_d = TRAVADO;
        end else if (cnt_q == EST) begin
          est_d  = TRAVADO;
          ult_d  = seg_r_q;
          aceita = 1'b1;
        end
      end
      default: est_d = OCIOSO;
    endcase
  end

  always_comb begin
    digito_d = digito_q;
    valor_d  = valor_q;
    cont_d   = cont_q;
    valido_d = aceita & cod_ok;
    erro_d   = aceita & ~cod_ok & (seg_r_q != BLANK);
    if (LIMPA) begin
      valor_d = '0;
      cont_d  = 4'd0;
    end
    if (valido_d) begin
      digito_d = cod;
      if (LIMPA) begin
        valor_d = VW'(cod);
        cont_d  = 4'd1;
      end else begin
        valor_d = (valor_q << 4) | VW'(cod);
        cont_d  = (cont_q == NMAX) ? NMAX : cont_q + 4'd1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      est_q    <= OCIOSO;
      seg_r_q  <= BLANK;
      cnt_q    <= 8'd0;
      ult_q    <= BLANK;
      digito_q <= 4'd0;
      valido_q <= 1'b0;
      erro_q   <= 1'b0;
      valor_q  <= '0;
      cont_q   <= 4'd0;
    end else begin
      est_q    <= est_d;
      seg_r_q  <= seg_r_d;
      cnt_q    <= cnt_d;
      ult_q    <= ult_d;
      digito_q <= digito_d;
      valido_q <= valido_d;
      erro_q   <= erro_d;
      valor_q  <= valor_d;
      cont_q   <= cont_d;
    end
  end

  assign DIGITO   = digito_q;
  assign VALIDO   = valido_q;
  assign ERRO     = erro_q;
  assign VALOR    = valor_q;
  assign CONTAGEM = cont_q;

endmodule
